controller_sequencer: RTL and testbench

SAP-1 controller-sequencer. A six-state ring counter (T1..T6) steps through fetch and execute. The block decodes the instruction-register opcode into the 12-bit control word that drives the program counter (Cp, Ep), MAR, RAM, IR, accumulator, adder/subtracter, B register and output register. It also implements halt and single-step control, and is the only source of Cp/Ep in the design.

---
 rtl/sap1_pkg.sv | 32 +++
 rtl/controller_sequencer_if.sv | 12 +
 rtl/ring_counter_6.sv | 16 +
 rtl/controller_sequencer.sv | 36 +++
 tb/tb_controller_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 opcodes, control-word constants and control-bit positions
package sap1_pkg;
   localparam int CW_WIDTH = 12;
   localparam int RING_LEN = 6;
   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;
   localparam logic [CW_WIDTH-1:0] CW_FETCH_T1 = 12'h5E3;
   localparam logic [CW_WIDTH-1:0] CW_FETCH_T2 = 12'hBE3;
   localparam logic [CW_WIDTH-1:0] CW_FETCH_T3 = 12'h263;
   localparam logic [CW_WIDTH-1:0] CW_LDA_T4   = 12'h1A3;
   localparam logic [CW_WIDTH-1:0] CW_LDA_T5   = 12'h2C3;
   localparam logic [CW_WIDTH-1:0] CW_ADD_T5   = 12'h2E1;
   localparam logic [CW_WIDTH-1:0] CW_ADD_T6   = 12'h3C7;
   localparam logic [CW_WIDTH-1:0] CW_SUB_T6   = 12'h3CF;
   localparam logic [CW_WIDTH-1:0] CW_OUT_T4   = 12'h3F2;
   localparam logic [CW_WIDTH-1:0] CW_INACTIVE = 12'h3E3;
   localparam int CP_BIT  = 11;
   localparam int EP_BIT  = 10;
   localparam int NLM_BIT = 9;
   localparam int NCE_BIT = 8;
   localparam int NLI_BIT = 7;
   localparam int NEI_BIT = 6;
   localparam int NLA_BIT = 5;
   localparam int EA_BIT  = 4;
   localparam int SU_BIT  = 3;
   localparam int EU_BIT  = 2;
   localparam int NLB_BIT = 1;
   localparam int NLO_BIT = 0;
endpackage

// File: rtl/controller_sequencer_if.sv
// controller_sequencer_if: opcode/mode inputs and control-word/state outputs of the sequencer
interface controller_sequencer_if;
   import sap1_pkg::*;
   logic [3:0]          Opcode;
   logic                Auto;
   logic                Step;
   logic [CW_WIDTH-1:0] CON;
   logic [RING_LEN-1:0] T;
   logic                HLT;
   modport master (output Opcode, Auto, Step, input CON, T, HLT);
   modport slave  (input Opcode, Auto, Step, output CON, T, HLT);
endinterface

// File: rtl/ring_counter_6.sv
// ring_counter_6: one-hot six-state ring with synchronous active-low clear and enable
module ring_counter_6
   import sap1_pkg::*;
(
   input  logic                nCLK,
   input  logic                nCLR,
   input  logic                en,
   output logic [RING_LEN-1:0] t
);
   logic [RING_LEN-1:0] t_d, t_q;
   // clear to T1, otherwise rotate toward T6 and wrap when enabled
   always_comb t_d = !nCLR ? RING_LEN'(1) : en ? {t_q[RING_LEN-2:0], t_q[RING_LEN-1]} : t_q;
   // state register
   always_ff @(posedge nCLK) t_q <= t_d;
   assign t = t_q;
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 T-state sequencing, opcode decode and halt/single-step control
module controller_sequencer
   import sap1_pkg::*;
(
   input logic                  nCLK,
   input logic                  nCLR,
   controller_sequencer_if.slave bus
);
   logic                halted_d, halted_q;
   logic                adv, halt_set;
   logic [RING_LEN-1:0] t;
   logic [CW_WIDTH-1:0] con_t4, con_t5, con_t6, con_dec;
   assign adv      = nCLR & ~halted_q & (bus.Auto | bus.Step);
   assign halt_set = adv & t[3] & (bus.Opcode == OP_HLT);
   // the halting edge freezes the ring at T4 instead of rotating
   ring_counter_6 u_ring (.nCLK(nCLK), .nCLR(nCLR), .en(adv & ~halt_set), .t(t));
   // halt is sticky until a reset edge
   always_comb halted_d = !nCLR ? 1'b0 : (halted_q | halt_set);
   // halt flag register
   always_ff @(posedge nCLK) halted_q <= halted_d;
   // execute-phase words decoded from the live opcode; unknown opcodes fall to NOP
   always_comb begin
      con_t4 = (bus.Opcode == OP_LDA || bus.Opcode == OP_ADD || bus.Opcode == OP_SUB) ? CW_LDA_T4 :
               (bus.Opcode == OP_OUT) ? CW_OUT_T4 : CW_INACTIVE;
      con_t5 = (bus.Opcode == OP_LDA) ? CW_LDA_T5 :
               (bus.Opcode == OP_ADD || bus.Opcode == OP_SUB) ? CW_ADD_T5 : CW_INACTIVE;
      con_t6 = (bus.Opcode == OP_ADD) ? CW_ADD_T6 :
               (bus.Opcode == OP_SUB) ? CW_SUB_T6 : CW_INACTIVE;
      con_dec = t[0] ? CW_FETCH_T1 : t[1] ? CW_FETCH_T2 : t[2] ? CW_FETCH_T3 :
                t[3] ? con_t4 : t[4] ? con_t5 : t[5] ? con_t6 : CW_INACTIVE;
   end
   // reset and halt both park the bus with every control inactive
   assign bus.CON = (!nCLR || halted_q) ? CW_INACTIVE : con_dec;
   assign bus.T   = t;
   assign bus.HLT = halted_q;
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: directed vector table plus multi-cycle sequences for the SAP-1 sequencer
module tb_controller_sequencer;
   typedef struct packed {
      logic        nclr;
      logic        auto_m;
      logic        step;
      logic [3:0]  op;
      logic [11:0] con;
      logic [5:0]  t;
      logic        hlt;
      logic        chk_state;
   } vec_t;

   logic nCLK = 0;
   logic nCLR = 0;
   controller_sequencer_if bus ();
   controller_sequencer dut (.nCLK(nCLK), .nCLR(nCLR), .bus(bus));

   always #5 nCLK = ~nCLK;

   int checks = 0;
   int errors = 0;
   int pc = 0;
   vec_t vecs[$];

   // program counter model: counts each edge seen with Cp asserted
   always @(posedge nCLK) pc <= !nCLR ? 0 : (bus.CON[11] ? pc + 1 : pc);

   task automatic add(input logic nclr, input logic a, input logic s, input logic [3:0] op,
                      input logic [11:0] con, input logic [5:0] t, input logic hlt, input logic c);
      vec_t v;
      v = '{nclr: nclr, auto_m: a, step: s, op: op, con: con, t: t, hlt: hlt, chk_state: c};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge nCLK);
      #1;
   endtask

   initial begin
      bus.Opcode = 4'h0;
      bus.Auto = 1'b1;
      bus.Step = 1'b0;
      // reset for two edges
      add(0, 1, 0, 4'h0, 12'h3E3, 6'b000000, 0, 0);
      add(0, 1, 0, 4'h0, 12'h3E3, 6'b000001, 0, 1);
      // LDA free-run
      add(1, 1, 0, 4'h0, 12'h5E3, 6'b000001, 0, 1);
      add(1, 1, 0, 4'h0, 12'hBE3, 6'b000010, 0, 1);
      add(1, 1, 0, 4'h0, 12'h263, 6'b000100, 0, 1);
      add(1, 1, 0, 4'h0, 12'h1A3, 6'b001000, 0, 1);
      add(1, 1, 0, 4'h0, 12'h2C3, 6'b010000, 0, 1);
      add(1, 1, 0, 4'h0, 12'h3E3, 6'b100000, 0, 1);
      // SUB
      add(1, 1, 0, 4'h2, 12'h5E3, 6'b000001, 0, 1);
      add(1, 1, 0, 4'h2, 12'hBE3, 6'b000010, 0, 1);
      add(1, 1, 0, 4'h2, 12'h263, 6'b000100, 0, 1);
      add(1, 1, 0, 4'h2, 12'h1A3, 6'b001000, 0, 1);
      add(1, 1, 0, 4'h2, 12'h2E1, 6'b010000, 0, 1);
      add(1, 1, 0, 4'h2, 12'h3CF, 6'b100000, 0, 1);
      // OUT
      add(1, 1, 0, 4'hE, 12'h5E3, 6'b000001, 0, 1);
      add(1, 1, 0, 4'hE, 12'hBE3, 6'b000010, 0, 1);
      add(1, 1, 0, 4'hE, 12'h263, 6'b000100, 0, 1);
      add(1, 1, 0, 4'hE, 12'h3F2, 6'b001000, 0, 1);
      add(1, 1, 0, 4'hE, 12'h3E3, 6'b010000, 0, 1);
      add(1, 1, 0, 4'hE, 12'h3E3, 6'b100000, 0, 1);
      // unknown opcode behaves as NOP through T4..T6, then HLT at T4
      add(1, 1, 0, 4'h7, 12'h5E3, 6'b000001, 0, 1);
      add(1, 1, 0, 4'h7, 12'hBE3, 6'b000010, 0, 1);
      add(1, 1, 0, 4'h7, 12'h263, 6'b000100, 0, 1);
      add(1, 1, 0, 4'h7, 12'h3E3, 6'b001000, 0, 1);
      add(1, 1, 0, 4'h7, 12'h3E3, 6'b010000, 0, 1);
      add(1, 1, 0, 4'h7, 12'h3E3, 6'b100000, 0, 1);
      add(1, 1, 0, 4'hF, 12'h5E3, 6'b000001, 0, 1);
      add(1, 1, 0, 4'hF, 12'hBE3, 6'b000010, 0, 1);
      add(1, 1, 0, 4'hF, 12'h263, 6'b000100, 0, 1);
      add(1, 1, 0, 4'hF, 12'h3E3, 6'b001000, 0, 1);
      for (int i = 0; i < 10; i++)
         add(1, 1'(i % 2), 1'((i / 2) % 2), (i < 5) ? 4'hF : 4'h1, 12'h3E3, 6'b001000, 1, 1);
      // reset clears halt
      add(0, 1, 0, 4'h0, 12'h3E3, 6'b001000, 1, 1);
      // single step: Step low holds T
      for (int i = 0; i < 5; i++)
         add(1, 0, 0, 4'h0, 12'h5E3, 6'b000001, 0, 1);
      add(1, 0, 1, 4'h0, 12'h5E3, 6'b000001, 0, 1);
      add(1, 0, 0, 4'h0, 12'hBE3, 6'b000010, 0, 1);
      add(1, 0, 0, 4'h0, 12'hBE3, 6'b000010, 0, 1);
      // Step held three edges
      add(1, 0, 1, 4'h0, 12'hBE3, 6'b000010, 0, 1);
      add(1, 0, 1, 4'h0, 12'h263, 6'b000100, 0, 1);
      add(1, 0, 1, 4'h0, 12'h1A3, 6'b001000, 0, 1);
      add(1, 0, 0, 4'h0, 12'h2C3, 6'b010000, 0, 1);
      add(1, 0, 0, 4'h0, 12'h2C3, 6'b010000, 0, 1);

      foreach (vecs[i]) begin
         nCLR = vecs[i].nclr;
         bus.Auto = vecs[i].auto_m;
         bus.Step = vecs[i].step;
         bus.Opcode = vecs[i].op;
         #1;
         check($sformatf("vec%0d CON", i), 32'(bus.CON), 32'(vecs[i].con));
         if (vecs[i].chk_state) begin
            check($sformatf("vec%0d T", i), 32'(bus.T), 32'(vecs[i].t));
            check($sformatf("vec%0d HLT", i), 32'(bus.HLT), 32'(vecs[i].hlt));
         end
         tick();
      end

      // one Cp pulse per instruction: SUB then OUT
      nCLR = 0; bus.Auto = 1; bus.Step = 0; bus.Opcode = 4'h2;
      tick();
      nCLR = 1;
      #1;
      check("pc start", 32'(pc), 32'd0);
      repeat (6) tick();
      check("pc after SUB", 32'(pc), 32'd1);
      check("T after SUB", 32'(bus.T), 32'h01);
      bus.Opcode = 4'hE;
      repeat (6) tick();
      check("pc after OUT", 32'(pc), 32'd2);

      // reset at T5 of an ADD suppresses the T6 word
      bus.Opcode = 4'h1;
      repeat (4) tick();
      check("ADD T5 CON", 32'(bus.CON), 32'h2E1);
      check("ADD T5 T", 32'(bus.T), 32'h10);
      nCLR = 0;
      #1;
      check("mid reset CON", 32'(bus.CON), 32'h3E3);
      tick();
      nCLR = 1;
      #1;
      check("after mid reset T", 32'(bus.T), 32'h01);
      check("after mid reset CON", 32'(bus.CON), 32'h5E3);
      check("after mid reset HLT", 32'(bus.HLT), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
